alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, width-parametrised ALU that succeeds the combinational 32-bit two-result ALU in the CPU datapath. It keeps that ALU's opcode map (0x00–0x11) and adds unsigned and signed iterative division. Operands enter and results leave through valid/ready handshakes, so the execute stage can stall on long operations. Exactly one operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 8. SHW = log2(WIDTH) is derived locally.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- op  in  8  opcode.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- q0, q1  out  WIDTH  primary and secondary results.
- st  out  4  flags: bit0 V, bit1 C, bit2 Z, bit3 N.
- err  out  1  the operation was an invalid opcode or a divide by zero.

## Operation
FSM states are IDLE, DIV, FIX and DONE.
- IDLE:
  - in_ready = 1.
  - An accepted single-cycle op (0x00–0x11) registers q0, q1, st and err, then goes to DONE.
  - An accepted 0x12 or 0x13 loads the divider, then goes to DIV.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - A counter runs from WIDTH-1 down to 0; at 0 the FSM goes to FIX.
- FIX: apply sign correction, special cases and flags, then go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready the FSM goes to IDLE.
  - q0, q1, st and err hold stable until the transfer.
- in_ready is high only in IDLE. No operation overlaps another.

Opcodes (WIDTH-generalised; results not listed are 0):
- 0x00 NOP: q0 = a, q1 = b, st = 0.
- 0x01 ADD: q0 = a+b.
- 0x02 SUB: q0 = a−b, computed as a+~b+1.
- 0x03 CPL: q0 = 0−a.
- 0x04 MUL: unsigned, {q1,q0} = a*b (2·WIDTH bits).
- Shifts by b[SHW-1:0]:
  - 0x05 SHR, 0x06 SHL.
  - 0x07 SAR sign-fills.
  - 0x08 SAL is identical to SHL.
  - 0x09 ROR, 0x0A ROL.
- Bitwise ops:
  - 0x0B NOT a.
  - 0x0C AND, 0x0D OR, 0x0E XOR, 0x0F NAND, 0x10 NOR, 0x11 XNOR.
- 0x12 DIVU: q0 = a/b, q1 = a%b, unsigned.
- 0x13 DIVS: signed. The quotient truncates toward zero; the remainder takes the dividend's sign.
- Any other opcode: q0 = q1 = 0, st = 0, err = 1, still one cycle.

Flags (Z = (q0 == 0) unless stated):
- ADD/SUB/CPL:
  - N = q0[MSB].
  - C = carry out of the WIDTH-bit add; for SUB, 1 means no borrow.
  - V = two's-complement overflow.
- MUL:
  - Z = ({q1,q0} == 0).
  - C = 0.
  - V = |q1.
- Shifts:
  - N = q0[MSB].
  - C = last bit shifted out; 0 when the amount is 0.
  - V = 0.
- Bitwise: Z only.
- Divides:
  - N = q0[MSB].
  - Z covers q0 only.
  - C = 0.
- Divide special cases:
  - b == 0: q0 = all ones, q1 = a, V = 1, err = 1.
  - DIVS with a = most-negative and b = −1: q0 = a, q1 = 0, V = 1, err = 0.
  - Special cases still traverse DIV and FIX, so latency is fixed.

## Timing
- Reset:
  - rst_n = 0 at an edge forces IDLE.
  - out_valid = 0, q0 = q1 = 0, st = 0, err = 0, and the counter clears.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-DIV or in DONE aborts the operation. No result is emitted.
- Latency, with acceptance at edge T (in_valid & in_ready):
  - Single-cycle op: out_valid is high after edge T+1.
  - Divide: out_valid is high after edge T+WIDTH+2, i.e. WIDTH cycles in DIV and one in FIX.
- Transfer happens at an edge with out_valid & out_ready. in_ready rises after that edge.
- Maximum throughput is one op per 2 cycles.
- Holding out_ready low stalls indefinitely without corrupting the result.
- Input changes while in_ready = 0 are ignored. Operands are captured only at acceptance.

## Test plan
- ADD, WIDTH=32:
  - Stimulus: a = 0x7FFFFFFF, b = 1.
  - Required: q0 = 0x80000000, st = 4'b1001 (N,V), out_valid exactly 1 cycle after accept.
- MUL:
  - Stimulus: a = 0xFFFFFFFF, b = 2.
  - Required: q0 = 0xFFFFFFFE, q1 = 1, V = 1, Z = 0.
- DIVU:
  - Stimulus: 100 / 7.
  - Required: q0 = 14, q1 = 2, out_valid first seen 34 cycles after accept.
- DIVS, both forms:
  - Stimulus: −7 / 2.
  - Required: q0 = −3, q1 = −1, N = 1.
  - Stimulus: 0x80000000 / −1.
  - Required: q0 = 0x80000000, V = 1.
- Divide by zero:
  - Stimulus: 5 / 0.
  - Required: q0 = 0xFFFFFFFF, q1 = 5, err = 1.
- Invalid opcode and reset abort:
  - Stimulus: op 0x20.
  - Required: err = 1, all results 0.
  - Stimulus: hold out_ready = 0 for 10 cycles.
  - Required: q0, q1, st and err stay constant.
  - Stimulus: rst_n low at cycle 5 of a DIVU.
  - Required: no out_valid, in_ready = 1 the next cycle.

Source files
------------

// File: rtl/alu_mc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_mc_if : request/response handshake bundle for the multi-cycle ALU    |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [3:0]       st;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, q0, q1, st, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, q0, q1, st, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_mc   : multi-cycle ALU, single-cycle ops plus iterative DIVU/DIVS    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  localparam int               c_SHW     = $clog2(WIDTH);
  localparam int               c_MSB     = WIDTH - 1;
  localparam logic [c_SHW-1:0] c_CNT_MAX = c_SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0]       c_OP_DIVU = 8'h12;
  localparam logic [7:0]       c_OP_DIVS = 8'h13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_in_ready;
  logic   w_out_valid;

  logic [WIDTH-1:0] r_q0, r_q1;
  logic [3:0]       r_st;
  logic             r_err;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_signed;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [c_SHW-1:0] r_cnt;

  logic [WIDTH-1:0]   w_q0, w_q1;
  logic [3:0]         w_st;
  logic               w_err;
  logic               w_div_op;
  logic [c_SHW-1:0]   w_sh, w_shm1, w_shn;
  logic [WIDTH-1:0]   w_srl, w_sll, w_sra, w_ror, w_rol;
  logic               w_co_r, w_co_l;
  logic [WIDTH-1:0]   w_add_x, w_add_y;
  logic               w_add_ci;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;

  logic [WIDTH:0]     w_dsh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_dtrial;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic               w_qneg, w_rneg;
  logic [WIDTH-1:0]   w_fq, w_fr;
  logic [WIDTH-1:0]   w_fix_q0, w_fix_q1;
  logic [3:0]         w_fix_st;
  logic               w_fix_err;

  assign w_div_op = (bus.op == c_OP_DIVU) || (bus.op == c_OP_DIVS);

  // Rotates reuse the logical shifts; at amount 0 both halves equal a.
  assign w_sh   = bus.b[c_SHW-1:0];
  assign w_shm1 = w_sh - 1'b1;
  assign w_shn  = -w_sh;
  assign w_srl  = bus.a >> w_sh;
  assign w_sll  = bus.a << w_sh;
  assign w_sra  = $signed(bus.a) >>> w_sh;
  assign w_ror  = w_srl | (bus.a << w_shn);
  assign w_rol  = w_sll | (bus.a >> w_shn);
  assign w_co_r = (w_sh != '0) && bus.a[w_shm1];
  assign w_co_l = (w_sh != '0) && bus.a[w_shn];

  assign w_add_x  = (bus.op == 8'h03) ? '0 : bus.a;
  assign w_add_y  = (bus.op == 8'h01) ? bus.b : ((bus.op == 8'h03) ? ~bus.a : ~bus.b);
  assign w_add_ci = (bus.op != 8'h01);
  assign w_add    = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_ci};
  assign w_prod   = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  assign w_mag_a = ((bus.op == c_OP_DIVS) && bus.a[c_MSB]) ? -bus.a : bus.a;
  assign w_mag_b = ((bus.op == c_OP_DIVS) && bus.b[c_MSB]) ? -bus.b : bus.b;

  always_comb begin
    w_q0  = '0;
    w_q1  = '0;
    w_st  = '0;
    w_err = 1'b0;
    case (bus.op)
      8'h00: begin
        w_q0 = bus.a;
        w_q1 = bus.b;
      end
      8'h01, 8'h02, 8'h03: begin
        w_q0 = w_add[WIDTH-1:0];
        w_st = {w_q0[c_MSB], (w_q0 == '0), w_add[WIDTH],
                (w_add_x[c_MSB] == w_add_y[c_MSB]) && (w_q0[c_MSB] != w_add_x[c_MSB])};
      end
      8'h04: begin
        w_q0 = w_prod[WIDTH-1:0];
        w_q1 = w_prod[2*WIDTH-1:WIDTH];
        w_st = {1'b0, (w_prod == '0), 1'b0, |w_prod[2*WIDTH-1:WIDTH]};
      end
      8'h05: begin
        w_q0 = w_srl;
        w_st = {w_q0[c_MSB], (w_q0 == '0), w_co_r, 1'b0};
      end
      8'h06, 8'h08: begin
        w_q0 = w_sll;
        w_st = {w_q0[c_MSB], (w_q0 == '0), w_co_l, 1'b0};
      end
      8'h07: begin
        w_q0 = w_sra;
        w_st = {w_q0[c_MSB], (w_q0 == '0), w_co_r, 1'b0};
      end
      8'h09: begin
        w_q0 = w_ror;
        w_st = {w_q0[c_MSB], (w_q0 == '0), w_co_r, 1'b0};
      end
      8'h0A: begin
        w_q0 = w_rol;
        w_st = {w_q0[c_MSB], (w_q0 == '0), w_co_l, 1'b0};
      end
      8'h0B: begin w_q0 = ~bus.a;            w_st[2] = (w_q0 == '0); end
      8'h0C: begin w_q0 = bus.a & bus.b;     w_st[2] = (w_q0 == '0); end
      8'h0D: begin w_q0 = bus.a | bus.b;     w_st[2] = (w_q0 == '0); end
      8'h0E: begin w_q0 = bus.a ^ bus.b;     w_st[2] = (w_q0 == '0); end
      8'h0F: begin w_q0 = ~(bus.a & bus.b);  w_st[2] = (w_q0 == '0); end
      8'h10: begin w_q0 = ~(bus.a | bus.b);  w_st[2] = (w_q0 == '0); end
      8'h11: begin w_q0 = ~(bus.a ^ bus.b);  w_st[2] = (w_q0 == '0); end
      8'h12, 8'h13: begin end
      default: w_err = 1'b1;
    endcase
  end

  // Restoring step: remainder stays below the divisor, so W bits suffice.
  assign w_dsh     = {r_rem, r_quo[c_MSB]};
  assign w_ge      = (w_dsh >= {1'b0, r_dvs});
  assign w_dtrial  = w_dsh[WIDTH-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_dtrial : w_dsh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  assign w_qneg = r_signed && (r_a[c_MSB] ^ r_b[c_MSB]);
  assign w_rneg = r_signed && r_a[c_MSB];
  assign w_fq   = w_qneg ? -r_quo : r_quo;
  assign w_fr   = w_rneg ? -r_rem : r_rem;

  always_comb begin
    w_fix_q0  = w_fq;
    w_fix_q1  = w_fr;
    w_fix_err = 1'b0;
    w_fix_st  = '0;
    if (r_b == '0) begin
      w_fix_q0    = '1;
      w_fix_q1    = r_a;
      w_fix_err   = 1'b1;
      w_fix_st[0] = 1'b1;
    end else if (r_signed && (r_a == c_MIN) && (r_b == '1)) begin
      w_fix_q0    = r_a;
      w_fix_q1    = '0;
      w_fix_st[0] = 1'b1;
    end
    w_fix_st[3] = w_fix_q0[c_MSB];
    w_fix_st[2] = (w_fix_q0 == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = w_div_op ? S_DIV : S_DONE;
        end
      end
      S_DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: w_state_nxt = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q0     <= '0;
      r_q1     <= '0;
      r_st     <= '0;
      r_err    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_signed <= (bus.op == c_OP_DIVS);
            if (w_div_op) begin
              r_rem <= '0;
              r_quo <= w_mag_a;
              r_dvs <= w_mag_b;
              r_cnt <= c_CNT_MAX;
            end else begin
              r_q0  <= w_q0;
              r_q1  <= w_q1;
              r_st  <= w_st;
              r_err <= w_err;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_q0  <= w_fix_q0;
          r_q1  <= w_fix_q1;
          r_st  <= w_fix_st;
          r_err <= w_fix_err;
        end
        default: begin end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.q0        = r_q0;
  assign bus.q1        = r_q1;
  assign bus.st        = r_st;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_mc : scoreboard bench for alu_mc with directed vectors (WIDTH=32) |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_alu_mc;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_bad;
  bit   seen;

  typedef struct {
    int          id;
    logic [31:0] q0;
    logic [31:0] q1;
    logic [3:0]  st;
    logic [3:0]  msk;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %h, expected %h", nm, id, act, exp);
    end
  endtask

  // Monitor: compares the head of the scoreboard on every cycle the result is
  // presented, so a stalled result must stay stable to keep matching.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", -1, 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb[0];
        if (!seen) begin
          chk("latency", e.id, 32'(cyc - e.acc), 32'(e.lat));
          seen = 1'b1;
        end
        chk("q0", e.id, bus.q0, e.q0);
        chk("q1", e.id, bus.q1, e.q1);
        chk("st", e.id, 32'(bus.st & e.msk), 32'(e.st & e.msk));
        chk("err", e.id, 32'(bus.err), 32'(e.err));
        if (bus.out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int id, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q0, input logic [31:0] q1, input logic [3:0] st,
                       input logic [3:0] msk, input logic err, input int lat, input bit push);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", id, 32'(bus.in_ready), 32'd1);
    end else begin
      e.id = id; e.q0 = q0; e.q1 = q1; e.st = st; e.msk = msk;
      e.err = err; e.lat = lat; e.acc = cyc;
      if (push) sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 8'hFF;
    bus.a  = 32'hDEADBEEF;
    bus.b  = 32'h0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("drain_timeout", -2, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    seen  = 1'b0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = 8'h00;
    bus.a  = '0;
    bus.b  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    chk("rst_q0", 0, bus.q0, 32'd0);
    chk("rst_q1", 0, bus.q1, 32'd0);
    chk("rst_st_err", 0, {27'd0, bus.err, bus.st}, 32'd0);

    //    id  op     a             b             q0            q1            st       msk    err lat
    issue( 1, 8'h01, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        4'b1001, 4'hF, 0,  1, 1);
    issue( 2, 8'h02, 32'h00000005, 32'h00000003, 32'h00000002, 32'h0,        4'b0010, 4'hF, 0,  1, 1);
    issue( 3, 8'h02, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0,        4'b1000, 4'hF, 0,  1, 1);
    issue( 4, 8'h03, 32'h00000000, 32'h12345678, 32'h00000000, 32'h0,        4'b0110, 4'hF, 0,  1, 1);
    issue( 5, 8'h04, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h1,        4'b0001, 4'h7, 0,  1, 1);
    issue( 6, 8'h05, 32'h80000001, 32'h00000001, 32'h40000000, 32'h0,        4'b0010, 4'hF, 0,  1, 1);
    issue( 7, 8'h07, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0,        4'b1000, 4'hF, 0,  1, 1);
    issue( 8, 8'h06, 32'hC0000000, 32'h00000001, 32'h80000000, 32'h0,        4'b1010, 4'hF, 0,  1, 1);
    issue( 9, 8'h09, 32'h00000001, 32'h00000001, 32'h80000000, 32'h0,        4'b1010, 4'hF, 0,  1, 1);
    issue(10, 8'h0A, 32'h80000001, 32'h00000004, 32'h00000018, 32'h0,        4'b0000, 4'hF, 0,  1, 1);
    issue(11, 8'h06, 32'h12345678, 32'h00000020, 32'h12345678, 32'h0,        4'b0000, 4'hF, 0,  1, 1);
    issue(12, 8'h0E, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000000, 32'h0,        4'b0100, 4'hF, 0,  1, 1);
    issue(13, 8'h0F, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'h0,        4'b0000, 4'hF, 0,  1, 1);
    issue(14, 8'h00, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 4'b0000, 4'hF, 0,  1, 1);
    issue(15, 8'h20, 32'h00000011, 32'h00000022, 32'h00000000, 32'h0,        4'b0000, 4'hF, 1,  1, 1);
    issue(16, 8'h12, 32'd100,      32'd7,        32'd14,       32'd2,        4'b0000, 4'hF, 0, 34, 1);
    issue(17, 8'h13, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 4'hF, 0, 34, 1);
    issue(18, 8'h13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        4'b1001, 4'hF, 0, 34, 1);
    issue(19, 8'h12, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        4'b1001, 4'hF, 1, 34, 1);
    issue(20, 8'h13, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 4'b1000, 4'hF, 0, 34, 1);
    issue(21, 8'h12, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h0,        4'b1000, 4'hF, 0, 34, 1);
    drain();

    // Stalled consumer: result must hold for the whole stall.
    bus.out_ready = 1'b0;
    issue(22, 8'h01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h0,        4'b0111, 4'hF, 0,  1, 1);
    repeat (10) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of a divide: nothing may be emitted afterwards.
    issue(23, 8'h12, 32'd100, 32'd7, 32'd0, 32'd0, 4'b0000, 4'hF, 0, 34, 0);
    chk("busy_in_ready", 23, 32'(bus.in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", 23, 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 23, 32'(bus.out_valid), 32'd0);
    chk("abort_q0", 23, bus.q0, 32'd0);
    chk("abort_st_err", 23, {27'd0, bus.err, bus.st}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_quiet", 23, 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
